// File: rtl/fxp_block_avg.sv
// fxp_block_avg: streaming mean and peak over blocks of 2^LOG2_N unsigned samples.
// FXP_AVG_ROUND_EN selects round-half-up division; undefined truncates.
module fxp_block_avg #(
    parameter int IN_W   = 4,
    parameter int FRAC   = 1,
    parameter int LOG2_N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IN_W-1:0] out_avg,
    output logic [IN_W-1:0] out_peak
);
    localparam int A_W = IN_W + LOG2_N;
`ifdef FXP_AVG_ROUND_EN
    localparam logic [A_W-1:0] RND = A_W'(1 << (LOG2_N - 1));
`else
    localparam logic [A_W-1:0] RND = '0;
`endif
    typedef enum logic {ACC, OUT} state_t;
    state_t state;
    logic [A_W-1:0] acc, acc_nxt;
    logic [LOG2_N-1:0] cnt;
    logic [IN_W-1:0] peak, peak_nxt, avg_nxt;
    if (LOG2_N < 1 || LOG2_N > 8 || FRAC > IN_W) begin : g_bad_cfg
        $error("fxp_block_avg: illegal LOG2_N/FRAC");
    end
    // the sum of N samples of at most 2^IN_W-1 plus the rounding half fits in A_W bits
    always_comb begin
        acc_nxt  = acc + A_W'(in_data);
        peak_nxt = in_data > peak ? in_data : peak;
        avg_nxt  = IN_W'((acc_nxt + RND) >> LOG2_N);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            peak      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_avg   <= '0;
            out_peak  <= '0;
        end else if (state == ACC) begin
            if (clr) begin
                acc  <= '0;
                cnt  <= '0;
                peak <= '0;
            end else if (in_valid) begin
                if (&cnt) begin
                    out_avg   <= avg_nxt;
                    out_peak  <= peak_nxt;
                    acc       <= '0;
                    cnt       <= '0;
                    peak      <= '0;
                    state     <= OUT;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                end else begin
                    acc  <= acc_nxt;
                    cnt  <= cnt + LOG2_N'(1);
                    peak <= peak_nxt;
                end
            end
        end else if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fxp_block_avg.sv
// tb_fxp_block_avg: directed scoreboard bench for fxp_block_avg (default LOG2_N = 3).
module tb_fxp_block_avg;
    localparam int IN_W = 4, LOG2_N = 3, N = 1 << LOG2_N;
    logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 1;
    logic [IN_W-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [IN_W-1:0] out_avg, out_peak;
    logic [2*IN_W-1:0] sb[$];
    logic [IN_W-1:0] exp_avg, exp_peak;
    int tests = 0, fails = 0;
    int r[N];

    fxp_block_avg #(.IN_W(IN_W), .FRAC(1), .LOG2_N(LOG2_N)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_avg(out_avg), .out_peak(out_peak)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int v);
        in_valid = 1;
        in_data  = IN_W'(v);
        @(negedge clk);
        in_valid = 0;
        in_data  = IN_W'($urandom);
    endtask

    task automatic send_block(input int s[N]);
        int sum = 0, mx = 0, ea;
        foreach (s[i]) begin
            sum += s[i];
            mx = s[i] > mx ? s[i] : mx;
        end
`ifdef FXP_AVG_ROUND_EN
        ea = (sum + N / 2) >> LOG2_N;
`else
        ea = sum >> LOG2_N;
`endif
        sb.push_back({IN_W'(ea), IN_W'(mx)});
        foreach (s[i]) send(s[i]);
    endtask

    task automatic wait_result(input string tag);
        int i;
        for (i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk({tag, "_latency"}, i, 0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            {exp_avg, exp_peak} = sb.pop_front();
            chk({tag, "_avg"}, out_avg, exp_avg);
            chk({tag, "_peak"}, out_peak, exp_peak);
            chk({tag, "_in_ready_out"}, in_ready, 0);
        end
        if (out_ready) begin
            @(negedge clk);
            chk({tag, "_valid_drop"}, out_valid, 0);
            chk({tag, "_in_ready_back"}, in_ready, 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_avg", out_avg, 0);
        chk("rst_peak", out_peak, 0);

        send_block('{15, 15, 15, 15, 15, 15, 15, 15});
        wait_result("all15");
        send_block('{0, 1, 2, 3, 4, 5, 6, 7});
        wait_result("ramp");
        send_block('{1, 1, 1, 1, 0, 0, 0, 0});
        wait_result("half");
        send_block('{1, 0, 0, 0, 0, 0, 0, 0});
        wait_result("single");

        // backpressure, with stray samples and a clr offered while the result is pending
        out_ready = 0;
        send_block('{2, 9, 4, 11, 6, 13, 8, 1});
        wait_result("bp");
        for (int c = 0; c < 5; c++) begin
            in_valid = 1;
            in_data  = 4'd14;
            clr      = (c == 2);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_avg_stable", out_avg, exp_avg);
            chk("bp_peak_stable", out_peak, exp_peak);
        end
        in_valid  = 0;
        clr       = 0;
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        send_block('{3, 3, 3, 3, 3, 3, 3, 3});
        wait_result("after_bp");

        // reset mid-block discards the partial sum and peak
        repeat (3) send(15);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_avg", out_avg, 0);
        send_block('{2, 2, 2, 2, 2, 2, 2, 2});
        wait_result("after_rst");

        // clr coincident with a valid sample drops it and the partial block
        repeat (5) send(15);
        clr      = 1;
        in_valid = 1;
        in_data  = 4'd15;
        @(negedge clk);
        clr      = 0;
        in_valid = 0;
        send_block('{1, 1, 1, 1, 1, 1, 1, 1});
        wait_result("after_clr");

        for (int b = 0; b < 3; b++) begin
            foreach (r[i]) r[i] = int'($urandom_range(0, 15));
            send_block(r);
            wait_result("rand");
        end

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
